// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes and multiply sequencer state encoding
package alu_pkg;

  localparam logic [3:0] ALU_MUL   = 4'd5;
  localparam logic [3:0] ALU_MADD  = 4'd6;
  localparam logic [3:0] ALU_MADDU = 4'd7;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  function automatic logic is_mult_op(input logic [3:0] ctrl);
    return (ctrl == ALU_MUL) || (ctrl == ALU_MADD) || (ctrl == ALU_MADDU);
  endfunction

endpackage

// File: rtl/mult_acc_datapath.sv
// rtl/mult_acc_datapath.sv - shift-add multiplier, sign fixup, HI/LO accumulate and MT writes
module mult_acc_datapath #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_fix,
  input  logic            i_commit,
  input  logic            i_mt_en,
  input  logic            i_signed,
  input  logic            i_acc,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_wr_hi,
  input  logic            i_wr_lo,
  input  logic [XLEN-1:0] i_wr_data,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [2*XLEN-1:0] r_prod;
  logic              r_neg;
  logic              r_acc;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;

  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_signed_prod;
  logic [2*XLEN-1:0] w_result;

  // Magnitudes are unsigned XLEN-bit, so negating the most-negative value yields its true magnitude.
  always_comb begin
    w_mag_a       = (i_signed && i_op_a[XLEN-1]) ? -i_op_a : i_op_a;
    w_mag_b       = (i_signed && i_op_b[XLEN-1]) ? -i_op_b : i_op_b;
    w_sum         = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    w_signed_prod = (i_fix && r_neg) ? -r_prod : r_prod;
    w_result      = r_acc ? ({r_hi, r_lo} + w_signed_prod) : w_signed_prod;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_neg    <= 1'b0;
      r_acc    <= 1'b0;
    end else if (i_load) begin
      r_mcand  <= w_mag_a;
      r_mplier <= w_mag_b;
      r_prod   <= '0;
      r_neg    <= i_signed & (i_op_a[XLEN-1] ^ i_op_b[XLEN-1]);
      r_acc    <= i_acc;
    end else if (i_step) begin
      r_prod   <= {w_sum, r_prod[XLEN-1:1]};
      r_mplier <= r_mplier >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_commit) begin
      {r_hi, r_lo} <= w_result;
    end else if (i_mt_en) begin
      if (i_wr_hi) r_hi <= i_wr_data;
      if (i_wr_lo) r_lo <= i_wr_data;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/mult_acc_seq.sv
// rtl/mult_acc_seq.sv - multi-cycle MUL/MADD/MADDU sequencer driving the HI/LO datapath
module mult_acc_seq
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic [XLEN-1:0] wr_data,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_load;
  logic             w_step;
  logic             w_fix;
  logic             w_commit;
  logic             w_mt_en;

  assign w_accept = start && is_mult_op(alu_ctrl);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_cnt <= '0;
    else if (w_load) r_cnt <= '0;
    else if (w_step) r_cnt <= r_cnt + CNT_W'(1);
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = CALC;
      CALC:    if (r_cnt == CNT_W'(XLEN - 1)) w_next = FIXUP;
      FIXUP:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // HI/LO are written on the FIXUP->DONE edge, so done marks the first cycle the commit is visible.
  always_comb begin
    busy     = (r_state != IDLE);
    done     = (r_state == DONE);
    w_mt_en  = (r_state == IDLE);
    w_load   = (r_state == IDLE) && w_accept;
    w_step   = (r_state == CALC);
    w_fix    = (r_state == FIXUP);
    w_commit = (r_state == FIXUP);
    stall    = busy || w_load;
  end

  mult_acc_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_fix     (w_fix),
    .i_commit  (w_commit),
    .i_mt_en   (w_mt_en),
    .i_signed  (alu_ctrl != ALU_MADDU),
    .i_acc     (alu_ctrl != ALU_MUL),
    .i_op_a    (op_a),
    .i_op_b    (op_b),
    .i_wr_hi   (wr_hi),
    .i_wr_lo   (wr_lo),
    .i_wr_data (wr_data),
    .o_hi      (hi),
    .o_lo      (lo)
  );

endmodule
